// File: rtl/huffman_encoding.sv
// Fixed-table Huffman encoder for 3-bit symbols: a small symbol FIFO feeds an
// MSB-first serializer that emits one code bit per enabled clock.
module huffman_encoding #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             EN,
  input  logic [2:0]       SYM_IN,
  input  logic             SYM_VALID,
  output logic             SYM_READY,
  output logic             CODING_OUT,
  output logic             CODE_VALID,
  output logic             CODE_LAST,
  output logic [CNT_W-1:0] BIT_COUNT
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [2:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] fill;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  state_t            state;
  state_t            state_nx;
  logic [3:0]        shreg;
  logic [3:0]        shreg_nx;
  logic [2:0]        rem;
  logic [2:0]        rem_nx;
  logic [6:0]        lookup;

  // Returns {length, left-aligned codeword}.
  function automatic logic [6:0] code_lookup(input logic [2:0] sym);
    logic [6:0] r;
    case (sym)
      3'd0:    r = {3'd2, 4'b0000};
      3'd1:    r = {3'd2, 4'b0100};
      3'd2:    r = {3'd3, 4'b1000};
      3'd3:    r = {3'd3, 4'b1010};
      3'd4:    r = {3'd4, 4'b1100};
      3'd5:    r = {3'd4, 4'b1101};
      3'd6:    r = {3'd4, 4'b1110};
      default: r = {3'd4, 4'b1111};
    endcase
    return r;
  endfunction

  assign full      = (fill == FILL_W'(FIFO_DEPTH));
  assign empty     = (fill == '0);
  assign SYM_READY = EN & ~nRST & ~full;
  assign push      = EN & SYM_VALID & SYM_READY;
  // Reloading while the last bit is on the wire keeps codewords back-to-back.
  assign pop       = EN & ~empty & ((state == IDLE) | (rem == 3'd1));
  assign lookup    = code_lookup(mem[rd_ptr]);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= SYM_IN;
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state <= IDLE;
      shreg <= '0;
      rem   <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      rem   <= rem_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    rem_nx   = rem;
    if (EN) begin
      if (pop) begin
        rem_nx   = lookup[6:4];
        shreg_nx = lookup[3:0];
      end else if (state == SHIFT) begin
        rem_nx   = rem - 3'd1;
        shreg_nx = {shreg[2:0], 1'b0};
      end
      state_nx = (rem_nx != 3'd0) ? SHIFT : IDLE;
    end
  end

  assign CODING_OUT = shreg[3];
  assign CODE_VALID = EN & (state == SHIFT);
  assign CODE_LAST  = CODE_VALID & (rem == 3'd1);

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      BIT_COUNT <= '0;
    end else if (CODE_VALID && (BIT_COUNT != '1)) begin
      BIT_COUNT <= BIT_COUNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_huffman_encoding.sv
// Directed bench for huffman_encoding: reset, single symbol, burst, enable
// pause, mid-codeword reset and bit-counter saturation.
module tb_huffman_encoding;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        EN;
  logic [2:0]  SYM_IN;
  logic        SYM_VALID;
  logic        SYM_READY;
  logic        CODING_OUT;
  logic        CODE_VALID;
  logic        CODE_LAST;
  logic [15:0] BIT_COUNT;

  int unsigned n_asserts = 0;
  int unsigned n_fails   = 0;

  huffman_encoding #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .EN        (EN),
    .SYM_IN    (SYM_IN),
    .SYM_VALID (SYM_VALID),
    .SYM_READY (SYM_READY),
    .CODING_OUT(CODING_OUT),
    .CODE_VALID(CODE_VALID),
    .CODE_LAST (CODE_LAST),
    .BIT_COUNT (BIT_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    next_cycle();
    nRST = 1'b0;
  endtask

  initial begin : main
    logic [31:0] stream;
    int unsigned nbits;
    int unsigned lasts;
    int unsigned sent;
    int unsigned first_v;
    int unsigned last_v;
    logic        saw_busy;

    nRST = 1'b1; EN = 1'b0; SYM_IN = '0; SYM_VALID = 1'b0;

    // Reset held 3 cycles with random inputs
    for (int i = 0; i < 3; i++) begin
      EN        = 1'($urandom);
      SYM_VALID = 1'($urandom);
      SYM_IN    = 3'($urandom);
      next_cycle();
      @(negedge CLK);
      chk("rst_ready", 32'(SYM_READY), 32'd0);
      chk("rst_valid", 32'(CODE_VALID), 32'd0);
      chk("rst_out", {30'd0, CODING_OUT, CODE_LAST}, 32'd0);
      chk("rst_count", 32'(BIT_COUNT), 32'd0);
    end
    next_cycle();
    nRST = 1'b0; EN = 1'b1; SYM_VALID = 1'b0;
    @(negedge CLK);
    chk("post_rst_ready", 32'(SYM_READY), 32'd1);
    chk("post_rst_valid", 32'(CODE_VALID), 32'd0);

    // Single symbol 2 -> 1,0,0 in cycles 2..4
    next_cycle();
    SYM_IN = 3'd2; SYM_VALID = 1'b1;
    next_cycle();
    SYM_VALID = 1'b0;
    @(negedge CLK);
    chk("single_c1_valid", 32'(CODE_VALID), 32'd0);
    next_cycle(); @(negedge CLK);
    chk("single_c2", {29'd0, CODE_VALID, CODING_OUT, CODE_LAST}, 32'b110);
    next_cycle(); @(negedge CLK);
    chk("single_c3", {29'd0, CODE_VALID, CODING_OUT, CODE_LAST}, 32'b100);
    next_cycle(); @(negedge CLK);
    chk("single_c4", {29'd0, CODE_VALID, CODING_OUT, CODE_LAST}, 32'b101);
    next_cycle(); @(negedge CLK);
    chk("single_c5_valid", 32'(CODE_VALID), 32'd0);
    chk("single_count", 32'(BIT_COUNT), 32'd3);

    // Burst of symbols 0..7 with SYM_VALID held while symbols remain
    stream = '0; nbits = 0; lasts = 0; sent = 0; first_v = 0; last_v = 0; saw_busy = 1'b0;
    for (int c = 0; c < 80; c++) begin
      next_cycle();
      SYM_VALID = (sent < 8);
      SYM_IN    = 3'(sent);
      @(negedge CLK);
      if (CODE_VALID) begin
        if (nbits == 0) first_v = c;
        last_v = c;
        stream = {stream[30:0], CODING_OUT};
        nbits++;
      end
      if (CODE_LAST) lasts++;
      if (sent < 8 && !SYM_READY) saw_busy = 1'b1;
      if (SYM_VALID && SYM_READY) sent++;
    end
    SYM_VALID = 1'b0;
    chk("burst_sent", sent, 32'd8);
    chk("burst_nbits", nbits, 32'd26);
    chk("burst_stream", stream, {6'd0, 26'b00011001011100110111101111});
    chk("burst_lasts", lasts, 32'd8);
    chk("burst_contig", last_v - first_v + 1, 32'd26);
    chk("burst_full_seen", 32'(saw_busy), 32'd1);
    chk("burst_count", 32'(BIT_COUNT), 32'd29);

    // Enable pause after the second bit of symbol 5
    do_reset();
    @(negedge CLK);
    chk("pause_rst_count", 32'(BIT_COUNT), 32'd0);
    next_cycle();
    SYM_IN = 3'd5; SYM_VALID = 1'b1;
    next_cycle();
    SYM_VALID = 1'b0;
    next_cycle(); @(negedge CLK);
    chk("pause_b0", {29'd0, CODE_VALID, CODING_OUT, CODE_LAST}, 32'b110);
    next_cycle(); @(negedge CLK);
    chk("pause_b1", {29'd0, CODE_VALID, CODING_OUT, CODE_LAST}, 32'b110);
    next_cycle();
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("pause_valid_low", 32'(CODE_VALID), 32'd0);
      chk("pause_ready_low", 32'(SYM_READY), 32'd0);
      next_cycle();
    end
    EN = 1'b1;
    @(negedge CLK);
    chk("pause_b2", {29'd0, CODE_VALID, CODING_OUT, CODE_LAST}, 32'b100);
    next_cycle(); @(negedge CLK);
    chk("pause_b3", {29'd0, CODE_VALID, CODING_OUT, CODE_LAST}, 32'b111);
    next_cycle(); @(negedge CLK);
    chk("pause_done_valid", 32'(CODE_VALID), 32'd0);
    chk("pause_count", 32'(BIT_COUNT), 32'd4);

    // Reset during the third bit of symbol 7
    next_cycle();
    SYM_IN = 3'd7; SYM_VALID = 1'b1;
    next_cycle();
    SYM_VALID = 1'b0;
    next_cycle(); next_cycle(); next_cycle();
    @(negedge CLK);
    chk("midrst_b2", {29'd0, CODE_VALID, CODING_OUT, CODE_LAST}, 32'b110);
    #1 nRST = 1'b1;
    #1;
    chk("midrst_async", {28'd0, SYM_READY, CODE_VALID, CODING_OUT, CODE_LAST}, 32'd0);
    chk("midrst_count", 32'(BIT_COUNT), 32'd0);
    next_cycle();
    nRST = 1'b0;
    SYM_IN = 3'd1; SYM_VALID = 1'b1;
    @(negedge CLK);
    chk("midrst_release_valid", 32'(CODE_VALID), 32'd0);
    next_cycle();
    SYM_VALID = 1'b0;
    @(negedge CLK);
    chk("midrst_c1_valid", 32'(CODE_VALID), 32'd0);
    next_cycle(); @(negedge CLK);
    chk("midrst_b0", {29'd0, CODE_VALID, CODING_OUT, CODE_LAST}, 32'b100);
    next_cycle(); @(negedge CLK);
    chk("midrst_b1", {29'd0, CODE_VALID, CODING_OUT, CODE_LAST}, 32'b111);
    next_cycle(); @(negedge CLK);
    chk("midrst_idle", 32'(CODE_VALID), 32'd0);
    chk("midrst_total", 32'(BIT_COUNT), 32'd2);

    // Continuous stream past 65535 bits
    do_reset();
    SYM_IN = 3'd0; SYM_VALID = 1'b1;
    repeat (65545) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("sat_streaming", 32'(CODE_VALID), 32'd1);
    chk("sat_count", 32'(BIT_COUNT), 32'h0000_FFFF);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    chk("sat_hold", 32'(BIT_COUNT), 32'h0000_FFFF);
    SYM_VALID = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
